// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit holding HI/LO.
// Shift-add multiply and restoring divide, WIDTH steps plus a fix-up cycle.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div0
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t             state;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opB;
   logic [WIDTH-1:0]   aRaw;
   logic               isDiv;
   logic               negHi;
   logic               negLo;
   logic               divZero;

   logic               signedOp;
   logic [WIDTH-1:0]   absA;
   logic [WIDTH-1:0]   absB;
   logic [WIDTH:0]     mulSum;
   logic [2*WIDTH-1:0] mulNext;
   logic [WIDTH:0]     divTop;
   logic [WIDTH:0]     divDiff;
   logic               divGe;
   logic [2*WIDTH-1:0] divNext;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   resHi;
   logic [WIDTH-1:0]   resLo;

   // Operand conditioning at the start edge: signed ops work on magnitudes.
   always_comb begin
      signedOp = ~op[0];
      absA     = (signedOp && a[WIDTH-1]) ? -a : a;
      absB     = (signedOp && b[WIDTH-1]) ? -b : b;
   end

   // One multiply step (shift-add) and one restoring divide step.
   always_comb begin
      mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opB};
      mulNext = acc[0] ? {mulSum, acc[WIDTH-1:1]}
                       : {1'b0, acc[2*WIDTH-1:1]};
      divTop  = acc[2*WIDTH-1:WIDTH-1];
      divDiff = divTop - {1'b0, opB};
      divGe   = (divTop >= {1'b0, opB});
      divNext = {(divGe ? divDiff[WIDTH-1:0] : divTop[WIDTH-1:0]),
                 acc[WIDTH-2:0], divGe};
   end

   // Sign correction and divide-by-zero override for the final write.
   always_comb begin
      prod  = negLo ? -acc : acc;
      resHi = prod[2*WIDTH-1:WIDTH];
      resLo = prod[WIDTH-1:0];
      if (isDiv) begin
         if (divZero) begin
            resHi = aRaw;
            resLo = '1;
         end else begin
            resHi = negHi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            resLo = negLo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
         end
      end
   end

   // Control FSM with registered busy/done and the HI/LO/div0 state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         acc     <= '0;
         opB     <= '0;
         aRaw    <= '0;
         isDiv   <= 1'b0;
         negHi   <= 1'b0;
         negLo   <= 1'b0;
         divZero <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         div0    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state   <= CALC;
                  count   <= '0;
                  busy    <= 1'b1;
                  aRaw    <= a;
                  isDiv   <= op[1];
                  divZero <= op[1] && (b == '0);
                  if (op[1]) begin
                     acc   <= {{WIDTH{1'b0}}, absA};
                     opB   <= absB;
                     negHi <= signedOp && a[WIDTH-1];
                     negLo <= signedOp && (a[WIDTH-1] ^ b[WIDTH-1]);
                  end else begin
                     acc   <= {{WIDTH{1'b0}}, absB};
                     opB   <= absA;
                     negHi <= 1'b0;
                     negLo <= signedOp && (a[WIDTH-1] ^ b[WIDTH-1]);
                  end
               end else begin
                  if (mthi) hi <= wdata;
                  if (mtlo) lo <= wdata;
               end
            end
            CALC: begin
               acc   <= isDiv ? divNext : mulNext;
               count <= count + 1'b1;
               if (count == LAST) state <= FIX;
            end
            FIX: begin
               hi    <= resHi;
               lo    <= resLo;
               div0  <= isDiv && divZero;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, signs, div-by-zero,
// back-to-back issue, ignored inputs while busy, MTHI/MTLO and reset abort.
module tb_mult_div_unit;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div0;

   int nAsserts = 0;
   int nFail    = 0;
   int doneCnt;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .mthi  (mthi),
      .mtlo  (mtlo),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo),
      .div0  (div0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present start for one edge (E0); busy must rise after it.
   task automatic launch(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input string tag);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, " busy@E0"}, {31'b0, busy}, 32'd1);
   endtask

   // Run E1..E33: still busy after E32, done pulse after E33.
   task automatic finish(input string tag);
      for (int i = 1; i <= 32; i++) tick();
      chk({tag, " busy@E32"}, {31'b0, busy}, 32'd1);
      chk({tag, " nodone@E32"}, {31'b0, done}, 32'd0);
      tick();
      chk({tag, " done@E33"}, {31'b0, done}, 32'd1);
      chk({tag, " idle@E33"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      a     = '0;
      b     = '0;
      mthi  = 1'b0;
      mtlo  = 1'b0;
      wdata = '0;
      tick();
      tick();
      chk("rst busy", {31'b0, busy}, 32'd0);
      chk("rst done", {31'b0, done}, 32'd0);
      chk("rst hi", hi, 32'h0);
      chk("rst lo", lo, 32'h0);
      chk("rst div0", {31'b0, div0}, 32'd0);
      rst = 1'b0;
      tick();

      // MULTU all-ones squared
      launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu");
      finish("multu");
      chk("multu hi", hi, 32'hFFFF_FFFE);
      chk("multu lo", lo, 32'h0000_0001);
      chk("multu div0", {31'b0, div0}, 32'd0);
      tick();
      chk("multu done1cyc", {31'b0, done}, 32'd0);

      // MULT -3*5, then DIV -7/2 issued in the done cycle
      launch(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, "mult");
      finish("mult");
      chk("mult hi", hi, 32'hFFFF_FFFF);
      chk("mult lo", lo, 32'hFFFF_FFF1);
      launch(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, "div");
      chk("b2b done drop", {31'b0, done}, 32'd0);
      chk("b2b hold lo", lo, 32'hFFFF_FFF1);
      finish("div");
      chk("div lo", lo, 32'hFFFF_FFFD);
      chk("div hi", hi, 32'hFFFF_FFFF);
      chk("div div0", {31'b0, div0}, 32'd0);

      // DIVU by zero, then a multiply clears div0
      launch(OP_DIVU, 32'h0000_0064, 32'h0, "divz");
      finish("divz");
      chk("divz lo", lo, 32'hFFFF_FFFF);
      chk("divz hi", hi, 32'h0000_0064);
      chk("divz div0", {31'b0, div0}, 32'd1);
      launch(OP_MULTU, 32'd2, 32'd3, "m23");
      finish("m23");
      chk("m23 hi", hi, 32'h0);
      chk("m23 lo", lo, 32'h6);
      chk("m23 div0", {31'b0, div0}, 32'd0);

      // Signed overflow
      launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "ovf");
      finish("ovf");
      chk("ovf lo", lo, 32'h8000_0000);
      chk("ovf hi", hi, 32'h0);
      chk("ovf div0", {31'b0, div0}, 32'd0);

      // DIVU 1000/7 with disturbances while busy
      launch(OP_DIVU, 32'd1000, 32'd7, "dist");
      doneCnt = 0;
      for (int i = 1; i <= 32; i++) begin
         if (i == 5) begin
            a  = 32'h1111_1111;
            b  = 32'h3;
            op = OP_MULT;
         end
         start = (i == 10);
         if (i == 12) begin
            mthi  = 1'b1;
            wdata = 32'hDEAD_BEEF;
         end else begin
            mthi = 1'b0;
         end
         tick();
         if (done) doneCnt++;
         if (i == 12) chk("dist hi held", hi, 32'h0);
      end
      start = 1'b0;
      mthi  = 1'b0;
      tick();
      if (done) doneCnt++;
      chk("dist lo", lo, 32'h0000_008E);
      chk("dist hi", hi, 32'h0000_0006);
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done) doneCnt++;
      end
      chk("dist done count", doneCnt, 32'd1);
      chk("dist idle", {31'b0, busy}, 32'd0);

      // MTLO while idle
      mtlo  = 1'b1;
      wdata = 32'h1234_5678;
      tick();
      mtlo = 1'b0;
      chk("mtlo lo", lo, 32'h1234_5678);
      chk("mtlo hi", hi, 32'h0000_0006);
      chk("mtlo done", {31'b0, done}, 32'd0);

      // Reset aborts an operation in flight
      launch(OP_MULTU, 32'd5, 32'd7, "abort");
      for (int i = 1; i <= 10; i++) tick();
      rst = 1'b1;
      #1;
      chk("abort busy", {31'b0, busy}, 32'd0);
      chk("abort done", {31'b0, done}, 32'd0);
      chk("abort hi", hi, 32'h0);
      chk("abort lo", lo, 32'h0);
      chk("abort div0", {31'b0, div0}, 32'd0);
      tick();
      rst = 1'b0;
      doneCnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done || busy) doneCnt++;
      end
      chk("abort no done", doneCnt, 32'd0);
      launch(OP_MULTU, 32'd7, 32'd6, "post");
      finish("post");
      chk("post lo", lo, 32'd42);
      chk("post hi", hi, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               nAsserts, nFail);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit for the MIPS execute stage. Implements MULT, MULTU, DIV and DIVU, and holds the architectural HI and LO registers.
- The hi and lo outputs feed the 32-bit 3-to-1 writeback/result select mux for MFHI/MFLO.
- busy is the stall request to pipeline control.

Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is supported. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin operation; sampled only when busy=0
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  32  operand A: multiplicand or dividend; captured at the start edge
- b  input  32  operand B: multiplier or divisor; captured at the start edge
- mthi  input  1  write wdata into HI
- mtlo  input  1  write wdata into LO
- wdata  input  32  data for MTHI/MTLO
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO are updated by an operation
- hi  output  32  HI register: product[63:32] or remainder
- lo  output  32  LO register: product[31:0] or quotient
- div0  output  1  last completed divide had b=0; updated with done

Behaviour:
- One clock: clk. Reset: rst, asynchronous, active-high.
- Reset values:
  - state=IDLE
  - busy=0, done=0, div0=0
  - hi=0, lo=0
  - iteration counter=0
- Reset mid-operation aborts the operation: no done, no HI/LO update.
- States: IDLE, CALC, FIX.
- IDLE:
  - Edge E0 with start=1: latch op, a, b. Unsigned ops use the raw operands. Signed ops take absolute values and record the result signs.
  - Go to CALC with count=0; busy=1 after E0.
- CALC:
  - One iteration per edge, E1..E32.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, 32-bit remainder, quotient bit shifted in.
  - At count==31, go to FIX.
- FIX (edge E33):
  - Apply sign correction.
  - Write hi/lo; set done=1 and busy=0 for the cycle after E33; set div0 (divides only; multiplies write div0=0).
  - Go to IDLE.
  - Latency: results are visible 33 cycles after the start edge.
- Back-to-back: start may be asserted in the cycle where done=1. It is accepted at the next edge.
- done deasserts after exactly one cycle.
- Operand stability: a, b and op are ignored after E0.
- start while busy=1 is ignored; there is no queueing.
- MTHI/MTLO:
  - Take effect at the edge only when busy=0 and start=0.
  - They are dropped if busy=1 or start=1 in the same cycle (start has priority).
  - mthi and mtlo together write both registers with wdata.
  - They do not pulse done and do not change div0.
- Signed multiply: full 64-bit two's-complement product. A negative result negates all 64 bits.
- Signed divide: quotient truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero (DIV or DIVU), full 33-cycle latency retained:
  - lo=FFFF_FFFF, hi=a.
  - div0=1.
  - No sign correction.
- Signed overflow, DIV 8000_0000 / FFFF_FFFF: lo=8000_0000, hi=0000_0000, div0=0.
- hi and lo are registered. They hold their value during CALC; the old values remain readable while busy.

Test Plan:
- MULTU a=FFFF_FFFF b=FFFF_FFFF, start at E0 -> busy=1 for E0..E33, done pulse after E33, hi=FFFF_FFFE, lo=0000_0001, div0=0.
- MULT a=FFFF_FFFD (-3) b=0000_0005, then back-to-back DIV a=FFFF_FFF9 (-7) b=0000_0002 with start in the done cycle -> first hi=FFFF_FFFF lo=FFFF_FFF1; second lo=FFFF_FFFD hi=FFFF_FFFF, 33 cycles later.
- DIVU a=0000_0064 b=0 -> after 33 cycles lo=FFFF_FFFF, hi=0000_0064, div0=1. Next MULTU 2*3 -> hi=0, lo=6, div0=0.
- DIV a=8000_0000 b=FFFF_FFFF -> lo=8000_0000, hi=0, div0=0.
- During a DIVU 1000/7, change a/b at E5, pulse start at E10, pulse mthi wdata=DEAD_BEEF at E12 -> all ignored: lo=0000_008E, hi=0000_0006, exactly one done.
- After the previous case: mtlo wdata=1234_5678 while idle -> lo=1234_5678 next cycle, done=0. Then start MULTU and assert rst at E10 -> busy, done, hi, lo and div0 all 0 immediately; no done follows; a new start after rst release completes normally.
